// File: rtl/cart_bus_ctrl.sv
// Cartridge edge-connector bus controller: turns single-byte CPU requests into
// one-M-cycle (8 pllClk) Game Boy bus cycles. It also provides the M-cycle boundary strobe.
module cart_bus_ctrl (
  input  logic        pllClk,
  input  logic        rstN,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [15:0] reqAddr,
  input  logic [7:0]  reqWdata,
  output logic        rspValid,
  output logic [7:0]  rspData,
  output logic        mCycleStart,
  output logic        cartClk,
  output logic        cartWrN,
  output logic        cartRdN,
  output logic        cartCsN,
  output logic [15:0] cartAddr,
  input  logic [7:0]  cartDin,
  output logic [7:0]  cartDout,
  output logic        cartDoe
);

  logic [2:0] phase;
  logic [2:0] nxt_phase;
  logic       active;
  logic       lat_write;
  logic       lat_cart;
  logic       lat_sram;
  logic [7:0] lat_wdata;

  logic       accept;
  logic       req_cart;
  logic       req_sram;
  logic       n_active;
  logic       n_write;
  logic       n_cart;
  logic       n_sram;
  logic [7:0] n_wdata;
  logic       cart_rd;
  logic       cart_wr;

  // Every pin is a flop loaded from the next-cycle view (phase + 1, next window
  // contents). This keeps the strobe edges on pllClk edges and keeps req* off the pins.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    nxt_phase = phase + 3'd1;
    accept    = (phase == 3'd7) && reqValid;
    req_cart  = (reqAddr <= 16'hFDFF);
    req_sram  = req_cart && (reqAddr >= 16'hA000);
    n_active  = active;
    n_write   = lat_write;
    n_cart    = lat_cart;
    n_sram    = lat_sram;
    n_wdata   = lat_wdata;
    if (phase == 3'd7) begin
      n_active = reqValid;
      n_write  = reqWrite;
      n_cart   = req_cart;
      n_sram   = req_sram;
      n_wdata  = reqWdata;
    end
    cart_rd = n_active && n_cart && !n_write;
    cart_wr = n_active && n_cart && n_write;
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops then update together on the edge.
  always_ff @(posedge pllClk) begin
    if (!rstN) begin
      phase       <= 3'd7;
      active      <= 1'b0;
      lat_write   <= 1'b0;
      lat_cart    <= 1'b0;
      lat_sram    <= 1'b0;
      lat_wdata   <= 8'h00;
      reqReady    <= 1'b1;
      mCycleStart <= 1'b0;
      cartClk     <= 1'b0;
      cartWrN     <= 1'b1;
      cartRdN     <= 1'b1;
      cartCsN     <= 1'b1;
      cartAddr    <= 16'h0000;
      cartDout    <= 8'h00;
      cartDoe     <= 1'b0;
      rspValid    <= 1'b0;
      rspData     <= 8'h00;
    end else begin
      phase  <= nxt_phase;
      active <= n_active;
      if (accept) begin
        lat_write <= reqWrite;
        lat_cart  <= req_cart;
        lat_sram  <= req_sram;
        lat_wdata <= reqWdata;
      end
      // Address pins only move for cartridge accesses and hold through everything else.
      if (accept && req_cart) begin
        cartAddr <= reqAddr;
      end

      reqReady    <= (nxt_phase == 3'd7);
      mCycleStart <= (nxt_phase == 3'd0);
      cartClk     <= (nxt_phase <= 3'd3);
      cartRdN     <= !(cart_rd && (nxt_phase >= 3'd1));
      cartWrN     <= !(cart_wr && (nxt_phase >= 3'd4) && (nxt_phase <= 3'd6));
      cartDoe     <= cart_wr && (nxt_phase >= 3'd3);
      cartDout    <= (cart_wr && (nxt_phase >= 3'd3)) ? n_wdata : 8'h00;
      cartCsN     <= !(n_active && n_sram && (nxt_phase >= 3'd2));

      // The edge that ends phase 7 closes the window. It samples cartDin and raises completion.
      rspValid <= (phase == 3'd7) && active;
      if ((phase == 3'd7) && active) begin
        rspData <= lat_write ? 8'h00 : (lat_cart ? cartDin : 8'hFF);
      end
    end
  end

endmodule

// File: doc/cart_bus_ctrl.md
# cart_bus_ctrl

Cartridge bus controller that sits directly upstream of the CPU. It owns the cartridge edge-connector pins (clock, /WR, /RD, /CS, address, data). It turns single-byte CPU read and write requests into Game Boy-timed bus cycles, each one M-cycle (8 pllClk) long, and returns fetched opcode or data bytes to the CPU over a valid/ready handshake. A free-running 8-phase M-cycle counter also gives the CPU its M-cycle boundary strobe.

## Interface
- No parameters. M-cycle length is fixed at 8 pllClk (2^23 Hz / 8 = 2^20 Hz bus rate).
- pllClk  in  1  2^23 Hz system clock; the only clock in the block.
- rstN  in  1  synchronous, active-low reset.
- reqValid  in  1  CPU request present.
- reqReady  out  1  request accepted on a cycle where reqValid && reqReady.
- reqWrite  in  1  1 = write, 0 = read.
- reqAddr  in  16  byte address.
- reqWdata  in  8  write data.
- rspValid  out  1  one-cycle pulse marking completion of an access.
- rspData  out  8  read byte; 8'h00 for writes.
- mCycleStart  out  1  high while phase == 0.
- cartClk  out  1  cartridge pin 2.
- cartWrN  out  1  cartridge pin 3, active low.
- cartRdN  out  1  cartridge pin 4, active low.
- cartCsN  out  1  cartridge pin 5, SRAM chip select, active low.
- cartAddr  out  16  cartridge address pins.
- cartDin  in  8  data from cartridge.
- cartDout  out  8  data to cartridge.
- cartDoe  out  1  output enable for the shared data pins.

## Operation
- 3-bit phase counter, free-running 0..7 and wrapping 7→0 whether or not an access is in progress.
- reqReady = (phase == 7). On acceptance the block latches reqAddr, reqWrite and reqWdata. The access occupies the next phases 0..7 (the "access window").
- Access classes:
  - cart: reqAddr ≤ 16'hFDFF.
  - internal: reqAddr ≥ 16'hFE00. Internal accesses are never presented to the cartridge.
- cartClk = 1 for phases 0–3 and 0 for phases 4–7, always, including when idle.
- cartAddr loads the latched address at phase 0 of a cart access window. It holds its value otherwise, including through idle and internal windows.
- Cart read: cartRdN low for phases 1–7. cartDin is sampled on the edge ending phase 7.
- Cart write:
  - cartDoe high and cartDout = wdata for phases 3–7.
  - cartWrN low for phases 4–6.
  - cartRdN stays high.
- cartCsN is low for phases 2–7 of a cart access with 16'hA000 ≤ addr ≤ 16'hFDFF; high otherwise.
- Completion: rspValid pulses during phase 0 following the access window. rspData is set as follows:
  - sampled byte for a cart read;
  - 8'hFF for an internal read;
  - 8'h00 for any write.
- rspData holds its value until the next completion.
- Idle windows, where nothing was accepted at the previous phase 7: all strobes inactive, cartDoe = 0, no rspValid.
- Reset values (all outputs):
  - phase = 7, so reqReady = 1 and mCycleStart = 0;
  - cartClk = 0, cartWrN = 1, cartRdN = 1, cartCsN = 1;
  - cartAddr = 16'h0000, cartDout = 8'h00, cartDoe = 0;
  - rspValid = 0, rspData = 8'h00.

## Timing
- Accept on cycle k (phase 7). Access phases 0..7 run on cycles k+1..k+8. rspValid is asserted on cycle k+9.
- Request-to-response latency is 9 cycles. Sustained throughput is one access per 8 cycles.
- Back-to-back: a new request may be accepted at phase 7 of the current window (cycle k+8). Its phase 0 is then the same cycle as the previous rspValid.
- A request not accepted waits; the CPU holds reqValid and its fields stable until reqReady.
- All outputs are registered and reflect the current phase. Strobe edges align to pllClk edges with no combinational path from req* to cart*.
- Reset mid-access: on the cycle after rstN is sampled low, all outputs take reset values. The in-flight access is discarded and no rspValid is produced for it. A request accepted on the same cycle that rstN is sampled low is also discarded.
- Phase 7 with reqValid = 0: the next window is idle.

## Test plan
- Reset: hold rstN low for 3 cycles, then release → all outputs at reset values during reset. On the first cycle after release reqReady = 1 and cartClk = 0. mCycleStart pulses every 8 cycles thereafter.
- Cart read: read 16'h0150 with cartDin = 8'h3E → cartAddr = 16'h0150 from k+1; cartRdN low k+2..k+8; cartCsN high; rspValid at k+9 only; rspData = 8'h3E.
- SRAM write: write 8'h5A to 16'hA000 →
  - cartCsN low k+3..k+8;
  - cartDoe high and cartDout = 8'h5A for k+4..k+8;
  - cartWrN low k+5..k+7;
  - cartRdN high throughout;
  - rspValid at k+9 with rspData = 8'h00.
- Back-to-back: reqValid held high for reads of 16'h0100 then 16'h0101 → accepts at k and k+8; rspValid at k+9 and k+17; cartRdN high for exactly one cycle (k+9) between the two accesses.
- Internal read: read 16'hFF44 → no strobe activity; cartAddr unchanged; rspValid at k+9 with rspData = 8'hFF.
- Reset mid-write: assert rstN low at access phase 4 of a write to 16'hA123 → on the next cycle cartWrN = 1, cartDoe = 0, cartCsN = 1; no rspValid for that access.
